// File: rtl/serial_adder32.sv
// serial_adder32 - byte-serial 32-bit adder for the byte-entry peripheral.
//
// Operands are latched on a rising edge of start, then summed one byte per
// clock (LSB byte first) with the inter-byte carry held in a flip-flop.
// The result and flags stay stable afterwards for the byte-wise display.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the op_sub port
// (1 = A-B, computed as A + ~B + 1).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      level request; only a 0->1 transition starts an operation
//   dataA      operand A, latched on the accepted start edge
//   dataB      operand B, latched on the accepted start edge
//   op_sub     subtract select (SERIAL_ADDER_SUB_EN only)
//   dataR      result register (partial while busy)
//   busy       high while bytes are being computed
//   done       one-cycle pulse when dataR/carry_out/overflow are final
//   carry_out  carry out of bit 31 (for subtract, 1 = no borrow)
//   overflow   two's-complement signed overflow
module serial_adder32 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic        op_sub,
`endif
   output logic [31:0] dataR,
   output logic        busy,
   output logic        done,
   output logic        carry_out,
   output logic        overflow
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic        start_q;
   logic        start_edge;
   logic [31:0] a_q, b_q;
   logic [1:0]  idx;
   logic        cy;
   logic        sub_sel;
   logic [4:0]  byte_sel;
   logic [8:0]  sum;

`ifdef SERIAL_ADDER_SUB_EN
   assign sub_sel = op_sub;
`else
   assign sub_sel = 1'b0;
`endif

   assign start_edge = start & ~start_q;
   assign byte_sel   = {idx, 3'b000};
   assign busy       = (state == RUN);

   // One byte lane per clock; bit 8 is the carry into the next byte.
   always_comb begin
      sum = {1'b0, a_q[byte_sel +: 8]} + {1'b0, b_q[byte_sel +: 8]} + {8'd0, cy};
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_edge) state_nxt = RUN;
         RUN:     if (idx == 2'd3) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         start_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         idx       <= 2'd0;
         cy        <= 1'b0;
         dataR     <= '0;
         done      <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         start_q <= start;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  a_q       <= dataA;
                  // Subtract is A + ~B + 1: invert B and seed the carry.
                  b_q       <= sub_sel ? ~dataB : dataB;
                  cy        <= sub_sel;
                  idx       <= 2'd0;
                  dataR     <= '0;
                  carry_out <= 1'b0;
                  overflow  <= 1'b0;
               end
            end
            RUN: begin
               dataR[byte_sel +: 8] <= sum[7:0];
               cy                   <= sum[8];
               idx                  <= idx + 2'd1;
               if (idx == 2'd3) begin
                  carry_out <= sum[8];
                  // Same-sign operands producing a different-sign result.
                  overflow  <= (a_q[31] == b_q[31]) & (sum[7] != a_q[31]);
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
